// File: rtl/cmd_dispatch.sv
// cmd_dispatch: time-ordered command queue between the command processor and
// the pulse element. Words {cmda, cmd} strobed in by proc are buffered in a
// FIFO and released one per cycle when the free-running timer reaches the
// timestamp held in the top TIME_W bits of the command word.
//
// Ports
//   clk, resetn            clock, async active-low reset
//   in_strobe/cmda/cmd     write side from proc; in_ready = write accepted now
//   run, sync              run enables timer + dispatch; sync zeroes the timer
//   flush, clear_err       empty the FIFO; clear sticky error flags
//   out_strobe/cmda/cmd    one-cycle release strobe and released word
//   timer, count           current timer value, FIFO occupancy
//   overflow, late         sticky: write dropped / word released after its time
//
// state   | meaning
// --------+----------------------------------------------
// ST_STOP | timer holds, nothing is dispatched
// ST_RUN  | timer counts every clk, head released when due
module cmd_dispatch #(
  parameter int CMD_W      = 64,
  parameter int ADDR_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int TIME_W     = 24
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_strobe,
  input  logic [ADDR_W-1:0]     in_cmda,
  input  logic [CMD_W-1:0]      in_cmd,
  output logic                  in_ready,
  input  logic                  run,
  input  logic                  sync,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic                  out_strobe,
  output logic [ADDR_W-1:0]     out_cmda,
  output logic [CMD_W-1:0]      out_cmd,
  output logic [TIME_W-1:0]     timer,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  late
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int ENT_W = ADDR_W + CMD_W;

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t state, state_nxt;
  logic   run_en;

  logic [ENT_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [ENT_W-1:0]      head;
  logic [TIME_W-1:0]     head_ts, diff;
  logic                  empty, full, pop, push, drop;

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_STOP;
    else         state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: if (run)  state_nxt = ST_RUN;
      ST_RUN:  if (!run) state_nxt = ST_STOP;
      default:           state_nxt = ST_STOP;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run_en = 1'b0;
    if (state == ST_RUN) run_en = 1'b1;
  end

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign head_ts = head[CMD_W-1 -: TIME_W];

  // Modular distance from the head timestamp to now; a clear MSB means the
  // timestamp is now or at most half the timer range in the past.
  assign diff = timer - head_ts;
  assign pop  = !empty && run_en && !diff[TIME_W-1];

  assign in_ready = !full || pop;
  assign push     = in_strobe && in_ready && !flush;
  assign drop     = in_strobe && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_cmda, in_cmd};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     timer <= '0;
    else if (sync)   timer <= '0;
    else if (run_en) timer <= timer + 1'b1;
  end

  // Released word is registered; flush only empties the queue, so a pop
  // decided this cycle still reaches the element.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_strobe <= 1'b0;
      out_cmda   <= '0;
      out_cmd    <= '0;
    end else begin
      out_strobe <= pop;
      if (pop) begin
        out_cmda <= head[ENT_W-1 -: ADDR_W];
        out_cmd  <= head[CMD_W-1:0];
      end
    end
  end

  // A new error in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      late     <= 1'b0;
    end else begin
      overflow <= (overflow && !clear_err) || drop;
      late     <= (late && !clear_err) || (pop && (diff != '0));
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
module tb_cmd_dispatch;

  localparam int CMD_W      = 64;
  localparam int ADDR_W     = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int TIME_W     = 8;

  logic                clk = 1'b0;
  logic                resetn;
  logic                in_strobe;
  logic [ADDR_W-1:0]   in_cmda;
  logic [CMD_W-1:0]    in_cmd;
  logic                in_ready;
  logic                run, sync, flush, clear_err;
  logic                out_strobe;
  logic [ADDR_W-1:0]   out_cmda;
  logic [CMD_W-1:0]    out_cmd;
  logic [TIME_W-1:0]   timer;
  logic [DEPTH_LOG2:0] count;
  logic                overflow, late;

  cmd_dispatch #(
    .CMD_W(CMD_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .TIME_W(TIME_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_strobe(in_strobe), .in_cmda(in_cmda), .in_cmd(in_cmd), .in_ready(in_ready),
    .run(run), .sync(sync), .flush(flush), .clear_err(clear_err),
    .out_strobe(out_strobe), .out_cmda(out_cmda), .out_cmd(out_cmd),
    .timer(timer), .count(count), .overflow(overflow), .late(late)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] cmda;
    logic [CMD_W-1:0]  cmd;
    logic [TIME_W-1:0] tmr;
    logic              lt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one write; when a release is expected, queue it with the timer
  // value and late flag the element should see alongside the strobe.
  task automatic send(input logic [7:0] a, input logic [7:0] ts, input logic [55:0] pl,
                      input bit expect_out, input logic [7:0] tmr, input bit lt);
    exp_t e;
    if (expect_out) begin
      e.cmda = a; e.cmd = {ts, pl}; e.tmr = tmr; e.lt = lt;
      exp_q.push_back(e);
    end
    in_strobe = 1'b1;
    in_cmda   = a;
    in_cmd    = {ts, pl};
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("pending_releases", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_timer(input logic [7:0] v);
    for (int i = 0; i < 300; i++) begin
      if (timer == v) break;
      tick();
    end
    check("wait_timer", 64'(timer), 64'(v));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_out_strobe", 64'(out_strobe), 64'd0);
    check("rst_out_cmda",   64'(out_cmda),   64'd0);
    check("rst_out_cmd",    out_cmd,         64'd0);
    check("rst_timer",      64'(timer),      64'd0);
    check("rst_count",      64'(count),      64'd0);
    check("rst_in_ready",   64'(in_ready),   64'd1);
    check("rst_overflow",   64'(overflow),   64'd0);
    check("rst_late",       64'(late),       64'd0);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && out_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got cmd %0h expected no strobe (t=%0t)", out_cmd, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_cmda",       64'(out_cmda), 64'(e.cmda));
          check("out_cmd",        out_cmd,       e.cmd);
          check("strobe_timer",   64'(timer),    64'(e.tmr));
          check("late_at_strobe", 64'(late),     64'(e.lt));
        end
      end
    end
  end

  initial begin
    logic [7:0] t;
    resetn = 1'b0; in_strobe = 1'b0; in_cmda = '0; in_cmd = '0;
    run = 1'b0; sync = 1'b0; flush = 1'b0; clear_err = 1'b0;
    #12;
    check_reset_outputs();
    tick();
    resetn = 1'b1;

    // 1: single word, ts=10, strobe lands as the timer steps to 11
    tick();
    run = 1'b1; sync = 1'b1;
    tick();
    sync = 1'b0;
    check("t1_timer_synced", 64'(timer), 64'd0);
    send(8'h11, 8'd10, 56'h00_1234_5678_9abc, 1'b1, 8'd11, 1'b0);
    wait_idle(40);
    check("t1_late", 64'(late), 64'd0);

    // 2: three back-to-back words, strobes on consecutive cycles
    sync = 1'b1;
    tick();
    sync = 1'b0;
    send(8'h21, 8'd5, 56'hA5_0000_0000_0005, 1'b1, 8'd6, 1'b0);
    send(8'h22, 8'd6, 56'h5A_0000_0000_0006, 1'b1, 8'd7, 1'b0);
    send(8'h23, 8'd7, 56'hFF_0000_0000_0007, 1'b1, 8'd8, 1'b0);
    wait_idle(40);
    check("t2_count_empty", 64'(count), 64'd0);
    check("t2_late", 64'(late), 64'd0);

    // 3: overflow with the timer stopped
    run = 1'b0;
    tick(); tick();
    for (int i = 0; i < 16; i++) send(8'(i), 8'd100, 56'(i), 1'b0, 8'd0, 1'b0);
    check("t3_count_full", 64'(count), 64'd16);
    check("t3_no_overflow_yet", 64'(overflow), 64'd0);
    check("t3_in_ready_full", 64'(in_ready), 64'd0);
    send(8'hEE, 8'd100, 56'hDEAD, 1'b0, 8'd0, 1'b0);
    check("t3_count_after_drop", 64'(count), 64'd16);
    check("t3_overflow", 64'(overflow), 64'd1);
    pulse_clear();
    check("t3_overflow_cleared", 64'(overflow), 64'd0);
    pulse_flush();
    check("t3_count_flushed", 64'(count), 64'd0);
    check("t3_in_ready", 64'(in_ready), 64'd1);

    // 4: late word released in 2 clk; word exactly half range ahead is held
    run = 1'b1; sync = 1'b1;
    tick();
    sync = 1'b0;
    wait_timer(8'd100);
    send(8'h41, 8'd50, 56'h00_0000_0000_4141, 1'b1, 8'd102, 1'b1);
    wait_idle(10);
    check("t4_late", 64'(late), 64'd1);
    t = timer;
    send(8'h42, t + 8'd129, 56'h4242, 1'b0, 8'd0, 1'b0);
    repeat (10) tick();
    check("t4_held_count", 64'(count), 64'd1);
    pulse_flush();
    check("t4_flushed", 64'(count), 64'd0);

    // 5: release across timer wrap
    pulse_clear();
    check("t5_late_cleared", 64'(late), 64'd0);
    wait_timer(8'd250);
    send(8'h51, 8'd3, 56'h55_5555_5555_5555, 1'b1, 8'd4, 1'b0);
    wait_idle(40);
    check("t5_late", 64'(late), 64'd0);

    // 6: flush (with a same-cycle push discarded), then reset mid-run
    t = timer;
    for (int i = 0; i < 4; i++) send(8'(8'h60 + i), t + 8'd100, 56'(i), 1'b0, 8'd0, 1'b0);
    check("t6_count_4", 64'(count), 64'd4);
    flush = 1'b1;
    send(8'h6F, t + 8'd100, 56'hF, 1'b0, 8'd0, 1'b0);
    flush = 1'b0;
    check("t6_flush_beats_push", 64'(count), 64'd0);
    send(8'h70, t + 8'd100, 56'h70, 1'b0, 8'd0, 1'b0);
    send(8'h71, t + 8'd100, 56'h71, 1'b0, 8'd0, 1'b0);
    check("t6_count_2", 64'(count), 64'd2);
    #3 resetn = 1'b0;
    #1 check_reset_outputs();
    tick();
    resetn = 1'b1;
    repeat (20) tick();
    check("t6_count_after_reset", 64'(count), 64'd0);

    check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
